// File: rtl/wb_rf_pkg.sv
// ---------------------------------------------------------------------------
// wb_rf_pkg -- shared constants and types for the WriteBack register file.
//   NREGS/AW/DW      : register count, index width, data width
//   PC_IDX           : architectural index aliased to the program counter
//   MAX_INFLIGHT     : outstanding writes tracked per register
//   reg_idx_t, word_t, sb_cnt_t : index, data word and scoreboard count types
// ---------------------------------------------------------------------------
package wb_rf_pkg;
    localparam int unsigned NREGS        = 16;
    localparam int unsigned AW           = 4;
    localparam int unsigned DW           = 32;
    localparam int unsigned PC_IDX       = 15;
    localparam int unsigned MAX_INFLIGHT = 3;

    typedef logic [AW-1:0] reg_idx_t;
    typedef logic [DW-1:0] word_t;
    typedef logic [1:0]    sb_cnt_t;
endpackage

// File: rtl/wb_regfile_sb_if.sv
// ---------------------------------------------------------------------------
// wb_regfile_sb_if -- WriteBack-to-register-file commit bus.
//   wb_reg_write : RegWriteOut, commit request
//   wb_pc_src    : PCSrcOut, an R15 commit becomes a fetch redirect
//   wb_rd        : RdOut, full-width destination (only low AW bits index)
//   wb_data      : OutData, value to commit
// Modports: master = WriteBack stage, slave = register file.
// ---------------------------------------------------------------------------
interface wb_regfile_sb_if;
    import wb_rf_pkg::*;

    logic  wb_reg_write;
    logic  wb_pc_src;
    word_t wb_rd;
    word_t wb_data;

    modport master (output wb_reg_write, output wb_pc_src, output wb_rd, output wb_data);
    modport slave  (input  wb_reg_write, input  wb_pc_src, input  wb_rd, input  wb_data);
endinterface

// File: rtl/wb_sb_counter.sv
// ---------------------------------------------------------------------------
// wb_sb_counter -- per-register pending-write counter (2-bit, saturating).
//   clk, rst  : clock, synchronous active-high reset
//   inc       : an instruction writing this register issued
//   dec       : WriteBack retired a write to this register
//   count     : outstanding writes
//   underflow : combinational, dec seen while count is zero
// ---------------------------------------------------------------------------
module wb_sb_counter
    import wb_rf_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    inc,
    input  logic    dec,
    output sb_cnt_t count,
    output logic    underflow
);

    always_comb begin
        underflow = dec & (count == '0);
    end

    // Simultaneous inc and dec cancel; both ends saturate.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && !dec && count != '1) begin
            count <= count + 2'd1;
        end else if (dec && !inc && count != '0) begin
            count <= count - 2'd1;
        end
    end

endmodule

// File: rtl/wb_regfile_sb.sv
// ---------------------------------------------------------------------------
// wb_regfile_sb -- architectural register file with pending-write scoreboard.
//   clk, rst         : clock, synchronous active-high reset
//   wb (slave)       : WriteBack commit bus
//   ra1/ra2, rd1/rd2 : combinational decode read ports
//   ra1_used/ra2_used: operand participates in the RAW hazard check
//   iss_valid/iss_writes/iss_rd : instruction issue from decode
//   stall            : issue blocked (RAW hazard or destination saturated)
//   pc_redirect/pc_target : one-cycle redirect pulse when WB writes R15
//   err_addr         : sticky, commit with nonzero wb_rd upper bits
//   err_underflow    : sticky, retirement of a register with no pending write
// Optional build macro WB_REGFILE_BYPASS_EN: same-cycle WB data forwarding to
// the read ports and early release of the last pending write in the stall
// check. Without it reads see stored values and busy follows the count only.
// ---------------------------------------------------------------------------
module wb_regfile_sb
    import wb_rf_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    wb_regfile_sb_if.slave    wb,
    input  reg_idx_t          ra1,
    input  reg_idx_t          ra2,
    input  logic              ra1_used,
    input  logic              ra2_used,
    output word_t             rd1,
    output word_t             rd2,
    input  logic              iss_valid,
    input  logic              iss_writes,
    input  reg_idx_t          iss_rd,
    output logic              stall,
    output logic              pc_redirect,
    output word_t             pc_target,
    output logic              err_addr,
    output logic              err_underflow
);

    localparam sb_cnt_t SB_FULL = sb_cnt_t'(MAX_INFLIGHT);

    word_t            regs [NREGS];
    sb_cnt_t          cnt  [NREGS];
    logic [NREGS-1:0] inc_vec;
    logic [NREGS-1:0] dec_vec;
    logic [NREGS-1:0] unf_vec;
    logic [NREGS-1:0] busy_vec;

    reg_idx_t wb_idx;
    logic     addr_ok;
    logic     commit;
    logic     pc_write;
    logic     wr_en;
    logic     do_issue;

    // Commit decode. A suppressed R15 write still retires its scoreboard entry.
    always_comb begin
        wb_idx   = wb.wb_rd[AW-1:0];
        addr_ok  = (wb.wb_rd[DW-1:AW] == '0);
        commit   = wb.wb_reg_write & addr_ok;
        pc_write = commit & wb.wb_pc_src & (wb_idx == reg_idx_t'(PC_IDX));
        wr_en    = commit & ~pc_write;
        do_issue = iss_valid & iss_writes & ~stall;
    end

    always_comb begin
        inc_vec  = '0;
        dec_vec  = '0;
        busy_vec = '0;
        for (int unsigned i = 0; i < NREGS; i++) begin
            inc_vec[i] = do_issue & (iss_rd == reg_idx_t'(i));
            dec_vec[i] = commit & (wb_idx == reg_idx_t'(i));
`ifdef WB_REGFILE_BYPASS_EN
            busy_vec[i] = (cnt[i] != '0) & ~((cnt[i] == 2'd1) & dec_vec[i]);
`else
            busy_vec[i] = (cnt[i] != '0);
`endif
        end
    end

    // stall depends on busy (driven by WB only), never on inc, so no loop.
    always_comb begin
        stall = iss_valid & ((ra1_used & busy_vec[ra1]) |
                             (ra2_used & busy_vec[ra2]) |
                             (iss_writes & (cnt[iss_rd] == SB_FULL)));
    end

    for (genvar g = 0; g < NREGS; g++) begin : g_cnt
        wb_sb_counter u_cnt (
            .clk       (clk),
            .rst       (rst),
            .inc       (inc_vec[g]),
            .dec       (dec_vec[g]),
            .count     (cnt[g]),
            .underflow (unf_vec[g])
        );
    end

    always_comb begin
`ifdef WB_REGFILE_BYPASS_EN
        rd1 = (wr_en && wb_idx == ra1) ? wb.wb_data : regs[ra1];
        rd2 = (wr_en && wb_idx == ra2) ? wb.wb_data : regs[ra2];
`else
        rd1 = regs[ra1];
        rd2 = regs[ra2];
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            pc_redirect   <= 1'b0;
            pc_target     <= '0;
            err_addr      <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            if (wr_en) begin
                regs[wb_idx] <= wb.wb_data;
            end
            pc_redirect <= pc_write;
            if (pc_write) begin
                pc_target <= wb.wb_data;
            end
            if (wb.wb_reg_write && !addr_ok) begin
                err_addr <= 1'b1;
            end
            if (|unf_vec) begin
                err_underflow <= 1'b1;
            end
        end
    end

endmodule
